// File: rtl/nonce_scan.sv
// nonce_scan: reads back per-nonce hash words, finds the minimum and compares it
// against the latched target. Optional NONCE_SCAN_EARLY_EXIT_EN stops at the first hit.
module nonce_scan #(
    parameter int unsigned NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] result_addr,
    input  logic [15:0] status_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [7:0]  best_nonce,
    output logic [31:0] best_hash,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    localparam logic [8:0] LAST_IDX = 9'(NUM_NONCES - 1);
    localparam logic [8:0] N_WORDS  = 9'(NUM_NONCES);

    state_t      state, state_nxt;
    logic [15:0] base_addr;
    logic [15:0] stat_addr;
    logic [31:0] tgt;
    logic [8:0]  rd_cnt;
    logic [8:0]  cmp_cnt;
    logic        issue;
    logic        cmp_valid;
    logic        last_cmp;
    logic        better;
    logic [31:0] new_best;
    logic        stop;

`ifdef NONCE_SCAN_EARLY_EXIT_EN
    // Set once a qualifying hash is seen; the following SCAN cycle only drains the read in flight.
    logic hit_pend;
    logic hit;
    assign stop = hit_pend;
    assign hit  = cmp_valid && (mem_read_data < tgt);
`else
    assign stop = 1'b0;
`endif

    assign mem_clk = clk;
    assign done    = (state == IDLE);

    always_comb begin
        issue     = (state == SCAN) && (rd_cnt < N_WORDS) && !stop;
        cmp_valid = (state == SCAN) && (cmp_cnt < rd_cnt) && !stop;
        last_cmp  = cmp_valid && (cmp_cnt == LAST_IDX);
        better    = mem_read_data < best_hash;
        new_best  = better ? mem_read_data : best_hash;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_cmp || stop) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (state == WRITE) begin
            mem_we         = 1'b1;
            mem_addr       = stat_addr;
            mem_write_data = {found, 15'b0, 8'b0, best_nonce};
        end else if (issue) begin
            mem_addr = base_addr + {7'b0, rd_cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            base_addr  <= '0;
            stat_addr  <= '0;
            tgt        <= '0;
            rd_cnt     <= '0;
            cmp_cnt    <= '0;
            found      <= 1'b0;
            best_nonce <= '0;
            best_hash  <= '1;
`ifdef NONCE_SCAN_EARLY_EXIT_EN
            hit_pend   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                base_addr  <= result_addr;
                stat_addr  <= status_addr;
                tgt        <= target;
                rd_cnt     <= '0;
                cmp_cnt    <= '0;
                found      <= 1'b0;
                best_nonce <= '0;
                best_hash  <= '1;
`ifdef NONCE_SCAN_EARLY_EXIT_EN
                hit_pend   <= 1'b0;
`endif
            end
            if (issue) rd_cnt <= rd_cnt + 9'd1;
            if (cmp_valid) begin
                cmp_cnt <= cmp_cnt + 9'd1;
                found   <= new_best < tgt;
                if (better) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= cmp_cnt[7:0];
                end
`ifdef NONCE_SCAN_EARLY_EXIT_EN
                if (hit && !last_cmp) hit_pend <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_nonce_scan.sv
// Self-checking bench for nonce_scan: table-driven scans on a 16-nonce instance plus
// directed sequences for reset, wrap, ignored start, back-to-back and NUM_NONCES=1.
module tb_nonce_scan;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start16 = 1'b0, start4 = 1'b0, start1 = 1'b0;
    logic [15:0] result_addr = '0, status_addr = '0;
    logic [31:0] target = '0;
    logic [31:0] rdata;

    logic        d16, f16, mc16, we16;
    logic [7:0]  n16;
    logic [31:0] h16, wd16;
    logic [15:0] a16;
    logic        d4, f4, mc4, we4;
    logic [7:0]  n4;
    logic [31:0] h4, wd4;
    logic [15:0] a4;
    logic        d1, f1, mc1, we1;
    logic [7:0]  n1;
    logic [31:0] h1, wd1;
    logic [15:0] a1;

    nonce_scan #(.NUM_NONCES(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .result_addr(result_addr),
        .status_addr(status_addr), .target(target), .done(d16), .found(f16),
        .best_nonce(n16), .best_hash(h16), .mem_clk(mc16), .mem_we(we16),
        .mem_addr(a16), .mem_write_data(wd16), .mem_read_data(rdata));

    nonce_scan #(.NUM_NONCES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .result_addr(result_addr),
        .status_addr(status_addr), .target(target), .done(d4), .found(f4),
        .best_nonce(n4), .best_hash(h4), .mem_clk(mc4), .mem_we(we4),
        .mem_addr(a4), .mem_write_data(wd4), .mem_read_data(rdata));

    nonce_scan #(.NUM_NONCES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .result_addr(result_addr),
        .status_addr(status_addr), .target(target), .done(d1), .found(f1),
        .best_nonce(n1), .best_hash(h1), .mem_clk(mc1), .mem_we(we1),
        .mem_addr(a1), .mem_write_data(wd1), .mem_read_data(rdata));

    // Shared memory model; sel picks which instance owns the port.
    logic [1:0]  sel = 2'd0;
    logic [31:0] mem [0:65535];
    logic        mwe;
    logic [15:0] maddr;
    logic [31:0] mwd;
    int unsigned wr_cnt = 0;
    logic [15:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    always_comb begin
        case (sel)
            2'd1:    begin mwe = we4; maddr = a4; mwd = wd4; end
            2'd2:    begin mwe = we1; maddr = a1; mwd = wd1; end
            default: begin mwe = we16; maddr = a16; mwd = wd16; end
        endcase
    end

    always @(posedge clk) begin
        rdata <= mem[maddr];
        if (mwe) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= maddr;
            wr_data <= mwd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          i1;
        logic [31:0] v1;
        int          i2;
        logic [31:0] v2;
        logic [31:0] tgt;
        logic        found;
        logic [7:0]  nonce;
        logic [31:0] hash;
        int          cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic load16(input vec_t v);
        for (int i = 0; i < 16; i++) mem[16'(16'h0100 + i)] = v.base;
        mem[16'(16'h0100 + v.i1)] = v.v1;
        mem[16'(16'h0100 + v.i2)] = v.v2;
    endtask

    task automatic run16(input vec_t v, input int idx);
        int          cyc;
        int unsigned w0;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        load16(v);
        sel = 2'd0;
        target = v.tgt;
        result_addr = 16'h0100;
        status_addr = 16'h0200;
        w0 = wr_cnt;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        check({tag, "_busy"}, {31'b0, d16}, 32'd0);
        // Inputs change after acceptance; only the latched copies may matter.
        target = 32'h0;
        result_addr = 16'hAAAA;
        status_addr = 16'h5555;
        cyc = 0;
        while (d16 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_cycles"}, 32'(cyc), 32'(v.cycles));
        check({tag, "_found"}, {31'b0, f16}, {31'b0, v.found});
        check({tag, "_nonce"}, {24'b0, n16}, {24'b0, v.nonce});
        check({tag, "_hash"}, h16, v.hash);
        check({tag, "_writes"}, wr_cnt - w0, 32'd1);
        check({tag, "_waddr"}, {16'b0, wr_addr}, 32'h0200);
        check({tag, "_wdata"}, wr_data, {v.found, 23'b0, v.nonce});
    endtask

    initial begin
        int          cyc;
        int unsigned w0;
        logic [15:0] alog[4];

`ifdef NONCE_SCAN_EARLY_EXIT_EN
        vecs[0] = '{32'h80000000, 5, 32'h00008000, 9, 32'h00000100, 32'h00010000, 1'b1, 8'd5, 32'h00008000, 9};
        vecs[2] = '{32'h00000050, 2, 32'h00000001, 7, 32'h00000001, 32'h00000002, 1'b1, 8'd2, 32'h00000001, 6};
        vecs[5] = '{32'h00000009, 0, 32'h00000003, 0, 32'h00000003, 32'hFFFFFFFF, 1'b1, 8'd0, 32'h00000003, 4};
`else
        vecs[0] = '{32'h80000000, 5, 32'h00008000, 9, 32'h00000100, 32'h00010000, 1'b1, 8'd9, 32'h00000100, 18};
        vecs[2] = '{32'h00000050, 2, 32'h00000001, 7, 32'h00000001, 32'h00000002, 1'b1, 8'd2, 32'h00000001, 18};
        vecs[5] = '{32'h00000009, 0, 32'h00000003, 0, 32'h00000003, 32'hFFFFFFFF, 1'b1, 8'd0, 32'h00000003, 18};
`endif
        vecs[1] = '{32'h00001000, 3, 32'h00000020, 3, 32'h00000020, 32'h00000010, 1'b0, 8'd3, 32'h00000020, 18};
        vecs[3] = '{32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 8'd0, 32'hFFFFFFFF, 18};
        vecs[4] = '{32'h70000000, 15, 32'h00000010, 0, 32'h00000020, 32'h00000015, 1'b1, 8'd15, 32'h00000010, 18};

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_done", {29'b0, d16, d4, d1}, 32'h7);
        check("rst_found", {31'b0, f16}, 32'd0);
        check("rst_nonce", {24'b0, n16}, 32'd0);
        check("rst_hash", h16, 32'hFFFFFFFF);
        check("rst_we", {29'b0, we16, we4, we1}, 32'd0);
        check("rst_addr", {16'b0, a16}, 32'd0);
        check("rst_wdata", wd16, 32'd0);
        check("mem_clk", {29'b0, mc16, mc4, mc1}, {29'b0, clk, clk, clk});
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run16(vecs[i], i);

        // Reset about five cycles into a scan suppresses the status write
        load16(vecs[0]);
        sel = 2'd0;
        target = vecs[0].tgt;
        result_addr = 16'h0100;
        status_addr = 16'h0200;
        w0 = wr_cnt;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_done", {31'b0, d16}, 32'd1);
        check("midrst_we", {31'b0, we16}, 32'd0);
        check("midrst_hash", h16, 32'hFFFFFFFF);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_nowrite", wr_cnt - w0, 32'd0);
        check("midrst_idle", {31'b0, d16}, 32'd1);

        // Address wrap with NUM_NONCES=4 and a start pulse during SCAN
        mem[16'hFFFE] = 32'h40;
        mem[16'hFFFF] = 32'h30;
        mem[16'h0000] = 32'h10;
        mem[16'h0001] = 32'h20;
        sel = 2'd1;
        target = 32'h5;
        result_addr = 16'hFFFE;
        status_addr = 16'h0300;
        w0 = wr_cnt;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        cyc = 0;
        while (d4 !== 1'b1 && cyc < 50) begin
            if (cyc < 4) alog[cyc] = a4;
            if (cyc == 2) start4 = 1'b1;
            if (cyc == 3) start4 = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("wrap_a0", {16'b0, alog[0]}, 32'hFFFE);
        check("wrap_a1", {16'b0, alog[1]}, 32'hFFFF);
        check("wrap_a2", {16'b0, alog[2]}, 32'h0000);
        check("wrap_a3", {16'b0, alog[3]}, 32'h0001);
        check("wrap_cycles", 32'(cyc), 32'd6);
        check("wrap_nonce", {24'b0, n4}, 32'd2);
        check("wrap_hash", h4, 32'h10);
        check("wrap_found", {31'b0, f4}, 32'd0);
        repeat (10) @(negedge clk);
        check("wrap_ignored_start", {31'b0, d4}, 32'd1);
        check("wrap_writes", wr_cnt - w0, 32'd1);
        check("wrap_wdata", wr_data, 32'h00000002);

        // NUM_NONCES=1: three busy cycles
        mem[16'h0400] = 32'h5;
        sel = 2'd2;
        target = 32'h6;
        result_addr = 16'h0400;
        status_addr = 16'h0410;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (d1 !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("n1_cycles", 32'(cyc), 32'd3);
        check("n1_found", {31'b0, f1}, 32'd1);
        check("n1_hash", h1, 32'h5);
        check("n1_wdata", wr_data, 32'h80000000);

        // Back-to-back: start held high, second scan must not see stale results
        load16(vecs[1]);
        sel = 2'd0;
        target = 32'h10;
        result_addr = 16'h0100;
        status_addr = 16'h0200;
        w0 = wr_cnt;
        @(negedge clk); start16 = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (d16 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_cycles1", 32'(cyc), 32'd18);
        check("b2b_nonce1", {24'b0, n16}, 32'd3);
        for (int i = 0; i < 16; i++) mem[16'(16'h0100 + i)] = 32'h1000;
        mem[16'h010C] = 32'h800;
        @(negedge clk);
        check("b2b_restart", {31'b0, d16}, 32'd0);
        start16 = 1'b0;
        cyc = 0;
        while (d16 !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_cycles2", 32'(cyc), 32'd18);
        check("b2b_nonce2", {24'b0, n16}, 32'd12);
        check("b2b_hash2", h16, 32'h800);
        check("b2b_found2", {31'b0, f16}, 32'd0);
        check("b2b_writes", wr_cnt - w0, 32'd2);
        check("b2b_wdata", wr_data, 32'h0000000C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_scan.md
# nonce_scan

Downstream stage of the 16-way bitcoin hasher. Once the hasher has written its per-nonce H0 words into shared memory, this block reads them back and compares each word, unsigned, against a difficulty target. It reports the winning nonce and its hash on ports, and writes one status word back to memory. It shares the hasher's memory port conventions and runs on the same clock.

## Interface
Parameters:
- NUM_NONCES, 16: number of consecutive hash words to scan; legal range 1..256.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
- start  in  1  level request; sampled only in IDLE.
- result_addr  in  16  base address of hash word for nonce 0.
- status_addr  in  16  address receiving the status word.
- target  in  32  difficulty threshold; a hash qualifies if hash < target (unsigned).
- done  out  1  high only in IDLE.
- found  out  1  a qualifying hash was seen in the last scan.
- best_nonce  out  8  index of the reported hash.
- best_hash  out  32  reported hash value.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  read data; valid the cycle after mem_addr is presented (1-cycle latency).

## Operation
- FSM states: IDLE, SCAN, WRITE.
- IDLE, start=1: latch result_addr, status_addr and target. Clear rd_cnt, cmp_cnt, found and best_nonce. Set best_hash=32'hFFFFFFFF. Go to SCAN.
- SCAN, address issue: while rd_cnt < NUM_NONCES, drive mem_addr = result_addr + rd_cnt (mod 2^16), then increment rd_cnt. Reads are pipelined at one word per cycle.
- SCAN, compare: from the second SCAN cycle, mem_read_data is hash[cmp_cnt], then cmp_cnt increments.
  - If hash < best_hash: best_hash=hash and best_nonce=cmp_cnt.
  - Ties keep the lower index.
  - found = (final best_hash < target).
  - Full scan therefore reports the global minimum, even when found=0.
- SCAN exit: after cmp_cnt reaches NUM_NONCES-1 is compared, go to WRITE.
- WRITE: one cycle.
  - mem_we=1, mem_addr=status_addr.
  - mem_write_data = {found, 15'b0, 8'b0, best_nonce}.
  - Then go to IDLE.
- Outputs found, best_nonce and best_hash update during SCAN. They are stable from IDLE entry until the next accepted start.
- start in SCAN or WRITE is ignored. start held high in IDLE restarts immediately.
- mem_we is 0 in every state except WRITE.
- target is taken only from the latched copy; input changes mid-scan have no effect.

## Timing
- Reset values: state=IDLE, done=1, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, mem_we=0, mem_addr=0, mem_write_data=0.
- Reset asserted in any state: IDLE at that edge, mem_we=0 from that edge, and the status write is suppressed.
- Start accepted at edge E0: done=0 after E0.
  - SCAN occupies NUM_NONCES+1 cycles.
  - WRITE occupies 1 cycle.
  - done=1 after edge E0+NUM_NONCES+2.
- NUM_NONCES=1: SCAN takes 2 cycles and total busy time is 3 cycles.
- Address wrap: result_addr=16'hFFFE with 4 nonces reads FFFE, FFFF, 0000, 0001.

## Configuration
- NONCE_SCAN_EARLY_EXIT_EN defined:
  - SCAN stops at the first hash < target and goes to WRITE on the next edge.
  - That index and hash are reported with found=1.
  - The outstanding read in flight is discarded; no further addresses are issued.
  - With no qualifying hash, behaviour is identical to a full scan.
- NONCE_SCAN_EARLY_EXIT_EN undefined: always full scan, reporting the minimum.

## Test plan
- Reset mid-scan, ~5 cycles into SCAN:
  - Response: done=1, mem_we=0, best_hash=FFFFFFFF.
  - No write ever reaches status_addr.
- 16 words at 0x0100, target=0x00010000:
  - Stimulus: hash[5]=0x00008000, hash[9]=0x00000100, all others 0x80000000.
  - Full scan: found=1, best_nonce=9, best_hash=0x00000100, status word 0x80000009 at status_addr.
  - Early-exit build: best_nonce=5, best_hash=0x00008000, done at E0+9.
- No hit, target=0x00000010:
  - Stimulus: all hashes 0x00001000 except hash[3]=0x00000020.
  - Response: found=0, best_nonce=3, status word 0x00000003.
  - done returns exactly 18 cycles after start is accepted.
- Ties: hash[2]=hash[7]=0x00000001, target=0x00000002.
  - Response: best_nonce=2 in both builds.
- Wrap and start handling:
  - Stimulus: result_addr=0xFFFE with NUM_NONCES=4; start pulsed during SCAN.
  - Response: reads issued to FFFE, FFFF, 0000, 0001; the extra start is ignored.
- Back-to-back: start held high across two scans.
  - Response: the second scan begins the cycle after IDLE.
  - Results are re-initialised; no stale best_hash carries over.
